// File: rtl/delay_line_pkg.sv
// Shared sizing helpers and depth clamping for the multi-lane delay line.
package delay_line_pkg;

    localparam int unsigned DEF_MAX_DEPTH = 32;

    function automatic int unsigned depth_w(input int unsigned max_depth);
        return $clog2(max_depth + 1);
    endfunction

    localparam int unsigned DEF_DEPTH_W = depth_w(DEF_MAX_DEPTH);

    typedef logic [DEF_DEPTH_W-1:0] depth_t;

    // Circular pointer spans 0..MAX_DEPTH-2; keep at least one bit.
    function automatic int unsigned ptr_w(input int unsigned max_depth);
        return (max_depth <= 2) ? 1 : $clog2(max_depth - 1);
    endfunction

    function automatic int unsigned clamp_depth(input int unsigned d, input int unsigned max_d);
        if (d == 0)
            return 1;
        else if (d > max_d)
            return max_d;
        else
            return d;
    endfunction

endpackage

// File: rtl/delay_line_mc_lane.sv
// One delay lane: N-1 entry circular RAM feeding an output register, with fill/valid tracking.
module delay_lane
    import delay_line_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned MAX_DEPTH = DEF_MAX_DEPTH,
    parameter int unsigned RST_DEPTH = 1,
    parameter int unsigned DEPTH_W   = depth_w(MAX_DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic               i_flush,
    input  logic               i_cfg_load,
    input  logic [DEPTH_W-1:0] i_cfg_depth,
    input  logic [WIDTH-1:0]   i_din,
    output logic [WIDTH-1:0]   o_dout,
    output logic               o_valid,
    output logic               o_clamped_c
);

    localparam int unsigned PTR_W = ptr_w(MAX_DEPTH);
    localparam int unsigned RAM_N = MAX_DEPTH - 1;

    logic [WIDTH-1:0]   r_ram [RAM_N];
    logic [PTR_W-1:0]   r_ptr;
    logic [DEPTH_W-1:0] r_depth;
    logic [DEPTH_W-1:0] r_fill;
    logic [WIDTH-1:0]   r_dout;
    logic               r_valid;

    logic               w_push;
    logic [DEPTH_W-1:0] w_fill_next;
    logic [PTR_W-1:0]   w_ptr_next;
    logic [DEPTH_W-1:0] w_depth_cl;

    assign w_push      = i_en & ~i_flush & ~i_cfg_load;
    assign w_fill_next = (r_fill >= r_depth) ? r_depth : r_fill + DEPTH_W'(1);
    assign w_ptr_next  = ((r_depth <= DEPTH_W'(1)) || (r_ptr == PTR_W'(r_depth - DEPTH_W'(2))))
                         ? '0 : r_ptr + PTR_W'(1);
    assign w_depth_cl  = DEPTH_W'(clamp_depth(32'(i_cfg_depth), MAX_DEPTH));
    assign o_clamped_c = (i_cfg_depth == '0) || (32'(i_cfg_depth) > MAX_DEPTH);

    // Storage is deliberately unreset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push && (r_depth > DEPTH_W'(1)))
            r_ram[r_ptr] <= i_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_depth <= DEPTH_W'(RST_DEPTH);
            r_fill  <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else if (i_cfg_load) begin
            r_depth <= w_depth_cl;
            r_ptr   <= '0;
            r_fill  <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_ptr   <= '0;
            r_fill  <= '0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_dout  <= (r_depth == DEPTH_W'(1)) ? i_din : r_ram[r_ptr];
            r_ptr   <= w_ptr_next;
            r_fill  <= w_fill_next;
            r_valid <= (w_fill_next >= r_depth);
        end
    end

    assign o_dout  = r_dout;
    assign o_valid = r_valid;

endmodule

// File: rtl/delay_line_mc.sv
// Multi-lane delay line: LANES independent delay_lane instances plus a clamp-error pulse.
module delay_line_mc
    import delay_line_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned LANES     = 4,
    parameter int unsigned MAX_DEPTH = DEF_MAX_DEPTH,
    parameter int unsigned RST_DEPTH = 1,
    parameter int unsigned DEPTH_W   = depth_w(MAX_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     cfg_load,
    input  logic [LANES*DEPTH_W-1:0] delay_depth,
    input  logic [LANES*WIDTH-1:0]   din,
    output logic [LANES*WIDTH-1:0]   dout,
    output logic [LANES-1:0]         dout_valid,
    output logic                     cfg_err
);

    logic [LANES-1:0] w_clamped;
    logic             r_cfg_err;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        delay_lane #(
            .WIDTH     (WIDTH),
            .MAX_DEPTH (MAX_DEPTH),
            .RST_DEPTH (RST_DEPTH),
            .DEPTH_W   (DEPTH_W)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_en        (en),
            .i_flush     (flush),
            .i_cfg_load  (cfg_load),
            .i_cfg_depth (delay_depth[l*DEPTH_W +: DEPTH_W]),
            .i_din       (din[l*WIDTH +: WIDTH]),
            .o_dout      (dout[l*WIDTH +: WIDTH]),
            .o_valid     (dout_valid[l]),
            .o_clamped_c (w_clamped[l])
        );
    end

    // Single-cycle pulse following a cfg_load where any lane was clamped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cfg_err <= 1'b0;
        else
            r_cfg_err <= cfg_load & (|w_clamped);
    end

    assign cfg_err = r_cfg_err;

endmodule
